// File: rtl/ritc_dac_pkg.sv
// Shared types and constants for the RITC serial DAC loader.
package ritc_dac_pkg;

    localparam int DAC_WORD_W       = 16;
    localparam int NUM_DACS_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_HIGH,
        ST_LATCH
    } dac_state_e;

endpackage

// File: rtl/ritc_dac_shadow_ram.sv
// Shadow copy of every DAC word in the chain: one write port, one registered read port.
// A same-cycle write to the address being read is forwarded, so a freshly loaded word is seen at once.
module ritc_dac_shadow_ram
    import ritc_dac_pkg::*;
#(
    parameter int DEPTH = NUM_DACS_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DAC_WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DAC_WORD_W-1:0] rdata_o
);

    logic [DAC_WORD_W-1:0] mem_q [DEPTH];
    logic [DAC_WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_q <= wdata_i;
            end else begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ritc_dac_loader.sv
// Loads DAC words into a shadow RAM and, on request, shifts the whole RAM MSB-first
// into the RITC serial DAC chain (highest index first), then pulses DAC_LATCH.
module ritc_dac_loader
    import ritc_dac_pkg::*;
#(
    parameter int NUM_DACS  = NUM_DACS_DEFAULT,
    parameter int CLK_DIV   = 4,
    parameter int LATCH_LEN = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DAC_WORD_W-1:0] value_i,
    input  logic [7:0]            addr_i,
    input  logic                  load_i,
    input  logic                  update_i,
    output logic                  updating_o,
    output logic                  DAC_SCLK,
    output logic                  DAC_DIN,
    output logic                  DAC_LATCH
);

    localparam int IDX_W = $clog2(NUM_DACS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W = (LATCH_LEN > 1) ? $clog2(LATCH_LEN) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DACS - 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(LATCH_LEN - 1);

    dac_state_e            state_q;
    logic [IDX_W-1:0]      word_idx_q;
    logic [3:0]            bit_cnt_q;
    logic [DIV_W-1:0]      div_q;
    logic [LAT_W-1:0]      lat_q;
    logic [DAC_WORD_W-1:0] shreg_q;
    logic                  updating_q;
    logic                  sclk_q;
    logic                  din_q;
    logic                  latch_q;

    logic                  idle;
    logic                  load_ok;
    logic                  div_done;
    logic                  word_done;
    logic [IDX_W-1:0]      rd_idx_d;
    logic [DAC_WORD_W-1:0] rdata;

    assign idle      = (state_q == ST_IDLE);
    assign load_ok   = idle && load_i && ({24'd0, addr_i} < NUM_DACS);
    assign div_done  = (div_q == DIV_MAX);
    assign word_done = (state_q == ST_HIGH) && div_done && (bit_cnt_q == 4'd15);

    // The read is issued one cycle ahead of FETCH so the word is waiting there:
    // from IDLE for the first word, from the last HIGH cycle for the rest.
    assign rd_idx_d = (word_done && (word_idx_q != '0)) ? (word_idx_q - IDX_W'(1)) : word_idx_q;

    ritc_dac_shadow_ram #(
        .DEPTH (NUM_DACS),
        .AW    (IDX_W)
    ) u_shadow (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .we_i    (load_ok),
        .waddr_i (addr_i[IDX_W-1:0]),
        .wdata_i (value_i),
        .raddr_i (rd_idx_d),
        .rdata_o (rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            word_idx_q <= LAST_IDX;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            lat_q      <= '0;
            shreg_q    <= '0;
            updating_q <= 1'b0;
            sclk_q     <= 1'b0;
            din_q      <= 1'b0;
            latch_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (update_i) begin
                        state_q    <= ST_FETCH;
                        updating_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    shreg_q <= rdata;
                    din_q   <= rdata[DAC_WORD_W-1];
                    div_q   <= '0;
                    state_q <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (div_done) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (div_done) begin
                        div_q     <= '0;
                        sclk_q    <= 1'b0;
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            din_q <= 1'b0;
                            if (word_idx_q == '0) begin
                                lat_q   <= '0;
                                latch_q <= 1'b1;
                                state_q <= ST_LATCH;
                            end else begin
                                word_idx_q <= word_idx_q - IDX_W'(1);
                                state_q    <= ST_FETCH;
                            end
                        end else begin
                            din_q   <= shreg_q[DAC_WORD_W-2];
                            state_q <= ST_SETUP;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (lat_q == LAT_MAX) begin
                        latch_q    <= 1'b0;
                        updating_q <= 1'b0;
                        word_idx_q <= LAST_IDX;
                        state_q    <= ST_IDLE;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign updating_o = updating_q;
    assign DAC_SCLK   = sclk_q;
    assign DAC_DIN    = din_q;
    assign DAC_LATCH  = latch_q;

endmodule

// File: tb/tb_ritc_dac_loader.sv
// Directed bench for ritc_dac_loader with NUM_DACS=4, CLK_DIV=2, LATCH_LEN=2.
module tb_ritc_dac_loader;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] value_i = '0;
    logic [7:0]  addr_i = '0;
    logic        load_i = 1'b0;
    logic        update_i = 1'b0;
    logic        updating_o;
    logic        DAC_SCLK;
    logic        DAC_DIN;
    logic        DAC_LATCH;

    int checks = 0;
    int fails  = 0;

    int          rises = 0;
    int          lpulses = 0;
    int          llen = 0;
    logic [63:0] cap = '0;
    logic        prev_sclk = 1'b0;
    logic        prev_latch = 1'b0;

    ritc_dac_loader #(
        .NUM_DACS  (4),
        .CLK_DIV   (2),
        .LATCH_LEN (2)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .value_i    (value_i),
        .addr_i     (addr_i),
        .load_i     (load_i),
        .update_i   (update_i),
        .updating_o (updating_o),
        .DAC_SCLK   (DAC_SCLK),
        .DAC_DIN    (DAC_DIN),
        .DAC_LATCH  (DAC_LATCH)
    );

    always #5 CLK = ~CLK;

    // Serial-side observer: records DIN at each SCLK rise and latch pulse shape.
    always @(negedge CLK) begin
        if (DAC_SCLK && !prev_sclk) begin
            rises <= rises + 1;
            cap   <= {cap[62:0], DAC_DIN};
        end
        if (DAC_LATCH && !prev_latch) begin
            lpulses <= lpulses + 1;
            llen    <= 1;
        end else if (DAC_LATCH) begin
            llen <= llen + 1;
        end
        prev_sclk  <= DAC_SCLK;
        prev_latch <= DAC_LATCH;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] v);
        value_i = v;
        addr_i  = a;
        load_i  = 1'b1;
        @(negedge CLK);
        load_i  = 1'b0;
    endtask

    task automatic run_update(input string tag, input logic [63:0] exp,
                              input int inj_n, input logic inj_ld, input logic inj_up,
                              input logic [7:0] inj_a, input logic [15:0] inj_v,
                              input logic same_ld, input logic [7:0] same_a,
                              input logic [15:0] same_v);
        int r0;
        int l0;
        int n;
        int first;
        r0 = rises;
        l0 = lpulses;
        update_i = 1'b1;
        if (same_ld) begin
            load_i  = 1'b1;
            addr_i  = same_a;
            value_i = same_v;
        end
        @(negedge CLK);
        update_i = 1'b0;
        load_i   = 1'b0;
        n = 1;
        first = 0;
        chk({tag, "_upd_hi"}, 64'(updating_o), 64'd1);
        while (updating_o && n < 400) begin
            if (DAC_SCLK && first == 0) first = n;
            if (n == inj_n) begin
                load_i   = inj_ld;
                update_i = inj_up;
                addr_i   = inj_a;
                value_i  = inj_v;
            end else if (n == inj_n + 1) begin
                load_i   = 1'b0;
                update_i = 1'b0;
            end
            @(negedge CLK);
            n++;
        end
        chk({tag, "_first_rise"}, 64'(first), 64'd4);
        chk({tag, "_upd_low_cyc"}, 64'(n), 64'd263);
        chk({tag, "_rises"}, 64'(rises - r0), 64'd64);
        chk({tag, "_latches"}, 64'(lpulses - l0), 64'd1);
        chk({tag, "_latch_len"}, 64'(llen), 64'd2);
        chk({tag, "_data"}, cap, exp);
        chk({tag, "_idle_outs"}, {61'd0, DAC_SCLK, DAC_DIN, DAC_LATCH}, 64'd0);
        repeat (3) @(negedge CLK);
        chk({tag, "_stays_idle"}, {32'(rises - r0), 31'd0, updating_o}, {32'd64, 32'd0});
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_updating", 64'(updating_o), 64'd0);
        chk("rst_sclk", 64'(DAC_SCLK), 64'd0);
        chk("rst_din", 64'(DAC_DIN), 64'd0);
        chk("rst_latch", 64'(DAC_LATCH), 64'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        load_word(8'd0, 16'h1234);
        load_word(8'd3, 16'hABCD);
        run_update("base", 64'hABCD_0000_0000_1234, -10, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0);

        run_update("busyload", 64'hABCD_0000_0000_1234, 30, 1'b1, 1'b0, 8'd1, 16'hFFFF, 1'b0, 8'd0, 16'h0);
        run_update("after_busyload", 64'hABCD_0000_0000_1234, -10, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0);

        run_update("busyupd", 64'hABCD_0000_0000_1234, 100, 1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0);

        load_word(8'd8, 16'h7777);
        run_update("same_cycle", 64'hABCD_5555_0000_1234, -10, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd2, 16'h5555);

        update_i = 1'b1;
        @(negedge CLK);
        update_i = 1'b0;
        repeat (50) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_updating", 64'(updating_o), 64'd0);
        chk("midrst_sclk", 64'(DAC_SCLK), 64'd0);
        chk("midrst_din", 64'(DAC_DIN), 64'd0);
        chk("midrst_latch", 64'(DAC_LATCH), 64'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        run_update("post_rst", 64'h0, -10, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
